// File: rtl/common_defs.sv
// rtl/common_defs.sv - shared SIMD controller encodings, write-back codes and wave sizing helpers
package common_defs;

  // Controller states; the numeric values are visible on simd_state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_REQUEST = 3'd3,
    ST_WAIT    = 3'd4,
    ST_EXECUTE = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } simd_state_e;

  // Register write-back source codes used by the decoder/register file.
  localparam logic [1:0] REG_WRITE_NONE  = 2'd0;
  localparam logic [1:0] REG_WRITE_ALU   = 2'd1;
  localparam logic [1:0] REG_WRITE_MEM   = 2'd2;
  localparam logic [1:0] REG_WRITE_CONST = 2'd3;

  // Number of lane groups needed to cover one wave.
  function automatic int total_wave_cycles(input int wave_size, input int lane_width);
    return (wave_size + lane_width - 1) / lane_width;
  endfunction

  // Width of the lane-group counter; never narrower than one bit.
  function automatic int wave_cycle_bits(input int wave_size, input int lane_width);
    int b;
    b = $clog2(total_wave_cycles(wave_size, lane_width));
    return (b < 1) ? 1 : b;
  endfunction

endpackage

// File: rtl/simd_controller_if.sv
// rtl/simd_controller_if.sv - dispatch/decode/LSU handshake bundle between a wave scheduler and simd_controller
//
// master: scheduler side (drives enable, simd_start, fetch_done, decode flags,
//         lsu_done, kernel metadata; observes state, lane group, mask, strobes)
// slave : simd_controller side
interface simd_controller_if #(
  parameter int LANE_WIDTH = 16,
  parameter int WAVE_SIZE  = 32
);
  import common_defs::*;

  localparam int CW = wave_cycle_bits(WAVE_SIZE, LANE_WIDTH);

  logic                   enable;
  logic                   simd_start;
  logic                   fetch_done;
  logic                   RET;
  logic                   MEM_READ;
  logic                   MEM_WRITE;
  logic [LANE_WIDTH-1:0]  lsu_done;
  logic [31:0]            num_threads;
  logic [31:0]            block_dim;
  logic signed [31:0]     block_id;
  logic signed [31:0]     wave_id;
  logic [2:0]             simd_state;
  logic [CW-1:0]          curr_wave_cycle;
  logic [LANE_WIDTH-1:0]  lane_mask;
  logic                   pc_advance;
  logic                   simd_done;

  modport master (
    output enable, simd_start, fetch_done, RET, MEM_READ, MEM_WRITE, lsu_done,
           num_threads, block_dim, block_id, wave_id,
    input  simd_state, curr_wave_cycle, lane_mask, pc_advance, simd_done
  );

  modport slave (
    input  enable, simd_start, fetch_done, RET, MEM_READ, MEM_WRITE, lsu_done,
           num_threads, block_dim, block_id, wave_id,
    output simd_state, curr_wave_cycle, lane_mask, pc_advance, simd_done
  );

endinterface

// File: rtl/simd_controller_lane_mask.sv
// rtl/simd_controller_lane_mask.sv - per-lane valid-thread mask for the current lane group
//
// Build option: SIMD_CTRL_TAIL_MASK_EN enables the tail mask; without it every
// lane is reported valid and the id/thread-count inputs are ignored.
//
// wave_cycle_i   : registered lane-group index
// num_threads_i  : threads in the kernel
// block_dim_i    : threads per block
// block_id_i     : signed block id (negative -> no valid lanes)
// wave_id_i      : signed wave id  (negative -> no valid lanes)
// lane_mask_o    : bit i set when lane i maps to a live thread
module simd_lane_mask #(
  parameter int LANE_WIDTH = 16,
  parameter int WAVE_SIZE  = 32,
  parameter int CW         = 1
) (
  input  logic [CW-1:0]          wave_cycle_i,
  input  logic [31:0]            num_threads_i,
  input  logic [31:0]            block_dim_i,
  input  logic signed [31:0]     block_id_i,
  input  logic signed [31:0]     wave_id_i,
  output logic [LANE_WIDTH-1:0]  lane_mask_o
);

`ifdef SIMD_CTRL_TAIL_MASK_EN
  logic [63:0] base_thread;

  // Thread index of lane 0; 64-bit so block_id*block_dim cannot wrap.
  always_comb begin
    base_thread = 64'(block_id_i[31:0]) * 64'(block_dim_i)
                + 64'(wave_id_i[31:0]) * 64'(WAVE_SIZE)
                + 64'(wave_cycle_i) * 64'(LANE_WIDTH);
    for (int i = 0; i < LANE_WIDTH; i++) begin
      lane_mask_o[i] = ((base_thread + 64'(i)) < 64'(num_threads_i));
    end
    if (block_id_i[31] || wave_id_i[31]) begin
      lane_mask_o = '0;
    end
  end
`else
  logic unused_mask_inputs;
  assign unused_mask_inputs = ^{wave_cycle_i, num_threads_i, block_dim_i, block_id_i, wave_id_i};
  assign lane_mask_o = '1;
`endif

endmodule

// File: rtl/simd_controller.sv
// rtl/simd_controller.sv - per-wave SIMD sequencing FSM (fetch, decode, per-lane-group memory wait, execute, update)
//
// Build option: SIMD_CTRL_TAIL_MASK_EN (tail lane masking inside simd_lane_mask).
//
// clk  : rising-edge clock
// rst  : asynchronous active-high reset
// bus  : simd_controller_if.slave
//        in : enable, simd_start, fetch_done, RET, MEM_READ, MEM_WRITE, lsu_done,
//             num_threads, block_dim, block_id, wave_id
//        out: simd_state, curr_wave_cycle, lane_mask, pc_advance, simd_done
module simd_controller
  import common_defs::*;
#(
  parameter int LANE_WIDTH = 16,
  parameter int WAVE_SIZE  = 32
) (
  input  logic               clk,
  input  logic               rst,
  simd_controller_if.slave   bus
);

  localparam int TWC = total_wave_cycles(WAVE_SIZE, LANE_WIDTH);
  localparam int CW  = wave_cycle_bits(WAVE_SIZE, LANE_WIDTH);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(TWC - 1);

  simd_state_e            state_q, state_d;
  logic [CW-1:0]          cwc_q, cwc_d;
  logic                   done_q, done_d;
  logic                   pc_adv;
  logic [LANE_WIDTH-1:0]  lane_mask;
  logic                   mem_op;
  logic                   lanes_acked;
  logic                   last_cycle;

  simd_lane_mask #(
    .LANE_WIDTH (LANE_WIDTH),
    .WAVE_SIZE  (WAVE_SIZE),
    .CW         (CW)
  ) u_lane_mask (
    .wave_cycle_i  (cwc_q),
    .num_threads_i (bus.num_threads),
    .block_dim_i   (bus.block_dim),
    .block_id_i    (bus.block_id),
    .wave_id_i     (bus.wave_id),
    .lane_mask_o   (lane_mask)
  );

  assign mem_op      = bus.MEM_READ | bus.MEM_WRITE;
  // Lanes without a live thread count as already acknowledged.
  assign lanes_acked = &(bus.lsu_done | ~lane_mask);
  assign last_cycle  = (cwc_q == LAST_CYCLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cwc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cwc_q   <= cwc_d;
      done_q  <= done_d;
    end
  end

  // Everything holds by default, which is also how enable=0 freezes the block.
  always_comb begin
    state_d = state_q;
    cwc_d   = cwc_q;
    done_d  = done_q;
    pc_adv  = 1'b0;
    if (bus.enable) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.simd_start) begin
            state_d = ST_FETCH;
            cwc_d   = '0;
          end
        end
        ST_FETCH: begin
          if (bus.fetch_done) state_d = ST_DECODE;
        end
        ST_DECODE:  state_d = ST_REQUEST;
        ST_REQUEST: state_d = ST_WAIT;
        ST_WAIT: begin
          if (!mem_op || lanes_acked) state_d = ST_EXECUTE;
        end
        ST_EXECUTE: state_d = ST_UPDATE;
        ST_UPDATE: begin
          if (!last_cycle) begin
            // Next lane group replays the same instruction.
            cwc_d   = cwc_q + 1'b1;
            state_d = ST_REQUEST;
          end else if (bus.RET) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cwc_d   = '0;
            pc_adv  = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_DONE: begin
          if (bus.simd_start) begin
            state_d = ST_FETCH;
            cwc_d   = '0;
            done_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.simd_state      = state_q;
  assign bus.curr_wave_cycle = cwc_q;
  assign bus.lane_mask       = lane_mask;
  assign bus.pc_advance      = pc_adv;
  assign bus.simd_done       = done_q;

endmodule

// File: tb/tb_simd_controller.sv
// tb/tb_simd_controller.sv - self-checking bench for simd_controller
module tb_simd_controller;

  localparam int LW  = 16;
  localparam int WS  = 32;
  localparam int TWC = (WS + LW - 1) / LW;

  typedef struct {
    bit           en;
    bit           start;
    bit           fdone;
    bit           ret;
    bit           rd;
    bit           wr;
    logic [LW-1:0] lsu;
    logic [LW-1:0] mask;
    int           st;
    int           cwc;
    bit           pc;
    bit           done;
  } step_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simd_controller_if #(.LANE_WIDTH(LW), .WAVE_SIZE(WS)) bus ();

  simd_controller #(.LANE_WIDTH(LW), .WAVE_SIZE(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  step_t plan[$];
  int          m_cwc = 0;
  bit          m_done = 0;
  bit          cur_ret = 0, cur_rd = 0, cur_wr = 0;
  bit          g_freeze = 0;
  int unsigned k_nt = 0, k_dim = 0;
  int          k_bid = 0, k_wid = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s@%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  // Lane i is valid when its global thread number is below the thread count.
  function automatic logic [LW-1:0] exp_mask(input int c);
    logic [LW-1:0] m;
    longint first_thread;
    m = '1;
    first_thread = 0;
`ifdef SIMD_CTRL_TAIL_MASK_EN
    first_thread = longint'(k_bid) * longint'(k_dim) + longint'(k_wid) * WS + longint'(c) * LW;
    for (int i = 0; i < LW; i++) m[i] = ((first_thread + i) < longint'(k_nt));
    if (k_bid < 0 || k_wid < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic set_kernel(input int unsigned nt, input int unsigned dim, input int bid, input int wid);
    k_nt = nt; k_dim = dim; k_bid = bid; k_wid = wid;
    bus.num_threads = nt;
    bus.block_dim   = dim;
    bus.block_id    = bid;
    bus.wave_id     = wid;
  endtask

  function automatic step_t mk(input int st);
    step_t s;
    s.en = 1; s.start = 0; s.fdone = 0;
    s.ret = cur_ret; s.rd = cur_rd; s.wr = cur_wr;
    s.lsu = '0; s.mask = exp_mask(m_cwc);
    s.st = st; s.cwc = m_cwc; s.pc = 0; s.done = m_done;
    return s;
  endfunction

  // Optionally precede a step with a disabled cycle showing the same state.
  task automatic push(input step_t s);
    step_t f;
    if (g_freeze && $urandom_range(0, 7) == 0) begin
      f = s; f.en = 0; f.pc = 0;
      f.start = 1'($urandom_range(0, 1));
      f.fdone = 1'($urandom_range(0, 1));
      f.lsu = LW'($urandom);
      plan.push_back(f);
    end
    plan.push_back(s);
  endtask

  task automatic gen_start();
    step_t s;
    s = mk(m_done ? 7 : 0);
    s.start = 1;
    push(s);
    m_cwc = 0; m_done = 0;
  endtask

  task automatic gen_hold(input int st, input int n);
    for (int k = 0; k < n; k++) push(mk(st));
  endtask

  // One instruction from FETCH through its last UPDATE.
  // lat_mode: 0 random acks, 1 lane i acks after i%5 cycles, 2 all ack at once.
  task automatic gen_instr(input bit rd, input bit wr, input bit ret, input int fd,
                           input int lat_mode, input bit spurious, input bit freeze_wait);
    step_t s;
    int lat[LW];
    int maxlat, w;
    logic [LW-1:0] m;
    cur_rd = rd; cur_wr = wr; cur_ret = ret;
    for (int k = 0; k <= fd; k++) begin
      s = mk(1); s.fdone = (k == fd);
      s.start = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      push(s);
    end
    s = mk(2); s.start = spurious ? 1'($urandom_range(0, 1)) : 1'b0; push(s);
    for (int c = 0; c < TWC; c++) begin
      m_cwc = c;
      s = mk(3); s.start = spurious ? 1'($urandom_range(0, 1)) : 1'b0; push(s);
      m = exp_mask(c);
      maxlat = 0;
      for (int i = 0; i < LW; i++) begin
        lat[i] = (lat_mode == 1) ? (i % 5) : (lat_mode == 2) ? 0 : int'($urandom_range(0, 4));
        if (m[i] && lat[i] > maxlat) maxlat = lat[i];
      end
      w = (rd || wr) ? maxlat + 1 : 1;
      if (freeze_wait && c == 0) begin
        for (int k = 0; k < 3; k++) begin
          s = mk(4); s.en = 0; s.lsu = '1; plan.push_back(s);
        end
      end
      for (int j = 0; j < w; j++) begin
        s = mk(4);
        s.start = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int i = 0; i < LW; i++) s.lsu[i] = (rd || wr) ? (m[i] && lat[i] <= j) : 1'($urandom_range(0, 1));
        push(s);
      end
      s = mk(5); s.start = spurious ? 1'($urandom_range(0, 1)) : 1'b0; push(s);
      s = mk(6); s.pc = (c == TWC - 1) && !ret;
      s.start = spurious ? 1'($urandom_range(0, 1)) : 1'b0; push(s);
    end
    if (ret) m_done = 1;
    else     m_cwc = 0;
  endtask

  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      bus.enable     = s.en;
      bus.simd_start = s.start;
      bus.fetch_done = s.fdone;
      bus.RET        = s.ret;
      bus.MEM_READ   = s.rd;
      bus.MEM_WRITE  = s.wr;
      bus.lsu_done   = s.lsu;
      #1;
      chk("state", 64'(bus.simd_state), 64'(s.st));
      chk("cwc", 64'(bus.curr_wave_cycle), 64'(s.cwc));
      chk("pc_advance", 64'(bus.pc_advance), 64'(s.pc));
      chk("simd_done", 64'(bus.simd_done), 64'(s.done));
      chk("lane_mask", 64'(bus.lane_mask), 64'(s.mask));
      step_no++;
    end
  endtask

  initial begin
    step_t s;
    int n;
    rst = 1'b1;
    bus.enable = 1; bus.simd_start = 0; bus.fetch_done = 0;
    bus.RET = 0; bus.MEM_READ = 0; bus.MEM_WRITE = 0; bus.lsu_done = '0;
    set_kernel(1000, 64, 0, 0);
    #2;
    chk("rst_state", 64'(bus.simd_state), 64'd0);
    chk("rst_cwc", 64'(bus.curr_wave_cycle), 64'd0);
    chk("rst_done", 64'(bus.simd_done), 64'd0);
    chk("rst_pc", 64'(bus.pc_advance), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    gen_hold(0, 2);
    run_plan();

    // ALU instruction twice over the lane groups, then RET with mid-wave starts.
    gen_start();
    gen_instr(0, 0, 0, 0, 0, 0, 0);
    gen_instr(0, 0, 1, 2, 0, 1, 0);
    gen_hold(7, 3);
    run_plan();

    // Memory read with staggered lane acknowledgements.
    gen_start();
    gen_instr(1, 0, 1, 0, 1, 0, 0);
    gen_hold(7, 1);
    run_plan();

    // Tail wave of 20 threads.
    set_kernel(20, 64, 0, 0);
    gen_start();
    gen_instr(1, 0, 0, 0, 1, 0, 0);
    gen_instr(0, 1, 1, 1, 0, 0, 0);
    gen_hold(7, 1);
    run_plan();

    // No live threads, then a negative block id.
    set_kernel(0, 64, 0, 0);
    gen_start();
    gen_instr(0, 1, 1, 0, 1, 0, 0);
    gen_hold(7, 1);
    run_plan();
    set_kernel(5000, 64, -1, 0);
    gen_start();
    gen_instr(1, 0, 1, 0, 1, 0, 0);
    gen_hold(7, 1);
    run_plan();

    // Freeze in WAIT with all lanes acknowledged.
    set_kernel(1000, 64, 0, 0);
    gen_start();
    gen_instr(1, 0, 1, 0, 2, 0, 1);
    gen_hold(7, 1);
    run_plan();

    // Reset while waiting on the second lane group.
    gen_start();
    cur_rd = 1; cur_wr = 0; cur_ret = 0;
    s = mk(1); s.fdone = 1; push(s);
    push(mk(2)); push(mk(3));
    s = mk(4); s.lsu = '1; push(s);
    push(mk(5)); push(mk(6));
    m_cwc = 1;
    push(mk(3));
    gen_hold(4, 3);
    run_plan();
    rst = 1'b1;
    #1;
    chk("async_rst_state", 64'(bus.simd_state), 64'd0);
    chk("async_rst_cwc", 64'(bus.curr_wave_cycle), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_cwc = 0; m_done = 0;
    gen_hold(0, 3);
    run_plan();

    // Randomised kernels with random freezes and spurious starts.
    g_freeze = 1;
    for (int k = 0; k < 12; k++) begin
      set_kernel($urandom_range(0, 100), $urandom_range(0, 48),
                 ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 2)),
                 ($urandom_range(0, 7) == 0) ? -2 : int'($urandom_range(0, 2)));
      gen_start();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        gen_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i == n - 1),
                  $urandom_range(0, 2), 0, 1, 0);
      end
      gen_hold(7, $urandom_range(1, 2));
      run_plan();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_controller.md
SIMD_CONTROLLER -- requirements
Module: simd_controller

Interface
REQ-001 SHALL have parameter LANE_WIDTH, default 16, lanes per wave cycle.
REQ-002 SHALL have parameter WAVE_SIZE, default 32, threads per wave; TOTAL_WAVE_CYCLES = ceil(WAVE_SIZE/LANE_WIDTH); CW = max(1, clog2(TOTAL_WAVE_CYCLES)).
REQ-003 SHALL have one clock; reset is asynchronous and active-high: clk input 1 (rising edge); rst input 1 (async, active-high).
REQ-004 SHALL have these ports:
- enable, input, 1: global run enable.
- simd_start, input, 1: wave dispatch pulse.
- fetch_done, input, 1: instruction latched by the fetcher.
- RET, MEM_READ, MEM_WRITE, input, 1 each: decoder outputs for the current instruction.
- lsu_done, input, LANE_WIDTH: per-lane LSU completion.
- num_threads, block_dim, input, 32 each: kernel metadata.
- block_id, wave_id, input, 32 signed each: dispatch ids.
- simd_state, output, 3: current state.
- curr_wave_cycle, output, CW: current lane group.
- lane_mask, output, LANE_WIDTH: lanes holding valid threads.
- pc_advance, output, 1: one-cycle PC increment strobe.
- simd_done, output, 1: wave retired.

Function
REQ-005 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7, and drive simd_state with the registered state.
REQ-006 SHALL make these transitions:
- IDLE, on simd_start: go to FETCH and set curr_wave_cycle=0.
- FETCH, on fetch_done: go to DECODE.
- DECODE: go to REQUEST after 1 cycle.
- REQUEST: go to WAIT after 1 cycle.
- EXECUTE: go to UPDATE after 1 cycle.
REQ-007 WAIT SHALL go to EXECUTE in the first WAIT cycle when MEM_READ=MEM_WRITE=0; otherwise it SHALL go to EXECUTE in the first cycle where (lsu_done | ~lane_mask) is all ones.
REQ-008 UPDATE with curr_wave_cycle < TOTAL_WAVE_CYCLES-1 SHALL increment curr_wave_cycle and go to REQUEST, re-using the current instruction.
REQ-009 UPDATE on the last cycle with RET=1 SHALL go to DONE; with RET=0 it SHALL reset curr_wave_cycle to 0, pulse pc_advance for exactly that UPDATE cycle, and go to FETCH.
REQ-010 DONE SHALL hold simd_done=1; simd_start in DONE SHALL clear simd_done, set curr_wave_cycle=0 and go to FETCH.
REQ-011 simd_start in states FETCH..UPDATE SHALL be ignored.
REQ-012 enable=0 SHALL freeze all state, counters and outputs, and SHALL force pc_advance=0.
REQ-013 With MEM_READ/MEM_WRITE set and lane_mask=0, WAIT SHALL exit after 1 cycle.
REQ-014 lane bit i SHALL be 1 iff block_id*block_dim + wave_id*WAVE_SIZE + curr_wave_cycle*LANE_WIDTH + i < num_threads.
REQ-015 The REQ-014 compare SHALL use 64-bit unsigned arithmetic, and any negative id SHALL give lane_mask=0.
REQ-016 lane_mask SHALL be combinational from the registered curr_wave_cycle and the inputs.

Reset
REQ-017 rst SHALL asynchronously force state=IDLE, curr_wave_cycle=0, simd_done=0 and pc_advance=0.
REQ-018 rst asserted mid-wave (e.g. in WAIT) SHALL abandon the wave; after release the block SHALL wait in IDLE for simd_start.

Configuration
REQ-019 SHALL implement macro SIMD_CTRL_TAIL_MASK_EN: when defined, lane_mask follows REQ-014/015; when undefined, lane_mask SHALL be constant all-ones and the id/num_threads inputs SHALL be unused.

Structure
REQ-020 The state encodings and TOTAL_WAVE_CYCLES function SHALL live in the shared common_defs package, alongside the REG_WRITE_* codes.
REQ-021 The mask computation SHALL be one sub-module, simd_lane_mask; the FSM SHALL stay in simd_controller.

Verification
REQ-022 The bench SHALL cover these scenarios:
- rst pulse during WAIT -> simd_state=0, curr_wave_cycle=0 asynchronously, before the next clk edge.
- simd_start with ALU instruction, RET=0, fetch_done 1 cycle later -> sequence 1,2,3,4,5,6,3,4,5,6,1; pc_advance high only on the second UPDATE.
- MEM_READ=1, lsu_done lanes raised over 5 cycles -> WAIT lasts until the last active lane acks, then EXECUTE.
- num_threads=20, block_id=0, wave_id=0 (TAIL_MASK_EN) -> lane_mask=0xFFFF on cycle 0, 0x000F on cycle 1; WAIT ignores lanes 4-15.
- RET=1 on last cycle -> DONE with simd_done=1; simd_start mid-wave ignored; simd_start in DONE -> FETCH, simd_done=0.
- enable=0 for 3 cycles in WAIT with lsu_done all ones -> state held, then EXECUTE on the first enabled cycle.
